pipeline_ctrl: RTL and testbench
================================

// Module: pipeline_ctrl
// PURPOSE
//  Central stall/flush scheduler for the 5-stage RV64I pipeline. Drives the PC enable plus
//  hold/bubble controls of the IF/ID and ID/EX pipe registers from hazard and control events.
//  ID/EX has no hold: its stall and flush inputs both load a zero bubble, so this block only
//  ever bubbles ID/EX and never holds it. Sequences load-use bubbles, EX-stage redirects,
//  fetch wait, system-instruction drain and ebreak halt.
// PARAMETERS
//  DRAIN_CYCLES  3   cycles an ID-stage system instr waits for older instrs to retire (>=1)
//  CNT_W         32  width of the stall performance counter
// PORTS
//  clk_i           in   1      clock, rising edge
//  rst_i           in   1      reset, asynchronous, active-high
//  id_valid_i      in   1      ID stage holds a real instruction
//  id_rs1_i        in   5      ID source register 1
//  id_rs2_i        in   5      ID source register 2
//  id_uses_rs1_i   in   1      ID instruction reads rs1
//  id_uses_rs2_i   in   1      ID instruction reads rs2
//  id_is_system_i  in   1      ID instruction is ecall/ebreak/fence/csr
//  id_is_ebreak_i  in   1      ID instruction is ebreak (qualifies id_is_system_i)
//  ex_valid_i      in   1      EX stage holds a real instruction
//  ex_rd_i         in   5      EX destination register
//  ex_is_load_i    in   1      EX instruction is a load
//  ex_redirect_i   in   1      EX resolved taken branch/jump/mispredict; PC takes target
//  imem_ready_i    in   1      instruction fetch data valid this cycle
//  pc_en_o         out  1      PC register may update
//  ifid_stall_o    out  1      IF/ID holds its contents
//  ifid_flush_o    out  1      IF/ID loads a bubble
//  idex_flush_o    out  1      ID/EX loads a bubble
//  sys_go_o        out  1      1-cycle pulse: system instr in ID released to EX
//  halted_o        out  1      core halted on ebreak
//  state_o         out  2      current ctrl_state_e (debug)
//  stall_cnt_o     out  CNT_W  cycles with pc_en_o==0 outside HALT, wraps
// BEHAVIOUR
//  States: RUN, DRAIN, HALT. While rst_i=1: state=RUN, cnt=0, stall_cnt_o=0, halted_o=0,
//   sys_go_o=0, pc_en_o=0, ifid_stall_o=0, ifid_flush_o=1, idex_flush_o=1.
//  load_use = ex_valid & ex_is_load & ex_rd!=0 & id_valid &
//             ((uses_rs1 & rs1==ex_rd) | (uses_rs2 & rs2==ex_rd)); rd==x0 never hazards.
//  Priority each cycle: HALT > redirect > DRAIN/system > load_use > fetch wait > normal.
//  HALT: pc_en=0, ifid_stall=1, idex_flush=1, halted_o=1; exit only by reset; counter frozen.
//  Redirect (ex_valid & ex_redirect, any non-HALT state): pc_en=1, ifid_flush=1,
//   idex_flush=1; DRAIN aborted -> RUN, cnt cleared, no sys_go_o.
//  RUN & id_valid & id_is_system & !load_use: -> DRAIN, cnt=DRAIN_CYCLES-1; that cycle and
//   all DRAIN cycles with cnt!=0: pc_en=0, ifid_stall=1, idex_flush=1; cnt decrements.
//   System instr that is also load_use: take the load-use bubble first, enter DRAIN next cycle.
//  DRAIN & cnt==0: sys_go_o=1, pc_en=1, no stall/bubble (instr moves to EX);
//   -> HALT if id_is_ebreak_i, else -> RUN. DRAIN_CYCLES=1: one held cycle, then release.
//  load_use (RUN): pc_en=0, ifid_stall=1, idex_flush=1; exactly one bubble per hazard.
//  Fetch wait (RUN, !imem_ready, no higher event): pc_en=0, ifid_flush=1, ID/EX loads.
//  Normal: pc_en=1, all stall/flush 0. ifid_stall_o & ifid_flush_o never both 1.
//  Control outputs are combinational from state + inputs; state, cnt, counter are flops.
//  stall_cnt_o += 1 on each clock edge where pc_en_o==0 and state!=HALT; wraps to 0.
// STRUCTURE
//  pipeline_pkg: typedef enum logic [1:0] {CTRL_RUN, CTRL_DRAIN, CTRL_HALT} ctrl_state_e.
//  Sub-module hazard_detect: combinational load_use compare (ID sources vs EX rd).
//  Top: FSM, drain counter ($clog2(DRAIN_CYCLES+1) bits), stall counter, output decode.
// TESTING
//  ld x5 in EX (rd=5), ID uses rs1=5 -> 1 cycle pc_en=0, ifid_stall=1, idex_flush=1.
//  ld x0 in EX, ID rs1=0 -> no stall; pc_en=1 throughout.
//  redirect with load_use same cycle -> pc_en=1, ifid_flush=1, idex_flush=1, no stall.
//  ecall in ID, DRAIN_CYCLES=3 -> 3 held cycles, sys_go_o on 4th, state back to RUN.
//  ecall draining, redirect on 2nd cycle -> RUN, sys_go_o never pulses.
//  ebreak in ID -> drain, sys_go_o, HALT; halted_o=1, stall_cnt_o frozen.
//  imem_ready=0 for 2 cycles -> ifid_flush=1, pc_en=0 for 2 cycles, stall_cnt_o=+2.
//  rst_i asserted mid-DRAIN -> immediate RUN, stall_cnt_o=0, no sys_go_o.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared types for the pipeline stall/flush scheduler.
// This covers the FSM state encoding and the bundle of pipe-register control outputs.
package pipeline_pkg;

    typedef enum logic [1:0] {
        CTRL_RUN   = 2'd0,
        CTRL_DRAIN = 2'd1,
        CTRL_HALT  = 2'd2
    } ctrl_state_e;

    typedef struct packed {
        logic pc_en;
        logic ifid_stall;
        logic ifid_flush;
        logic idex_flush;
    } ctrl_out_t;

    localparam ctrl_out_t CTL_NORMAL     = '{pc_en: 1'b1, ifid_stall: 1'b0, ifid_flush: 1'b0, idex_flush: 1'b0};
    localparam ctrl_out_t CTL_HOLD       = '{pc_en: 1'b0, ifid_stall: 1'b1, ifid_flush: 1'b0, idex_flush: 1'b1};
    localparam ctrl_out_t CTL_REDIRECT   = '{pc_en: 1'b1, ifid_stall: 1'b0, ifid_flush: 1'b1, idex_flush: 1'b1};
    localparam ctrl_out_t CTL_FETCH_WAIT = '{pc_en: 1'b0, ifid_stall: 1'b0, ifid_flush: 1'b1, idex_flush: 1'b0};
    localparam ctrl_out_t CTL_RESET      = '{pc_en: 1'b0, ifid_stall: 1'b0, ifid_flush: 1'b1, idex_flush: 1'b1};

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard compare: an ID-stage source matches the destination of a load in EX.
// Writes to x0 never create a hazard.
module hazard_detect (
    input  logic       i_id_valid,
    input  logic [4:0] i_id_rs1,
    input  logic [4:0] i_id_rs2,
    input  logic       i_id_uses_rs1,
    input  logic       i_id_uses_rs2,
    input  logic       i_ex_valid,
    input  logic [4:0] i_ex_rd,
    input  logic       i_ex_is_load,
    output logic       o_load_use
);

    logic w_ex_load_live;
    logic w_rs1_hit;
    logic w_rs2_hit;

    assign w_ex_load_live = i_ex_valid & i_ex_is_load & (i_ex_rd != 5'd0);
    assign w_rs1_hit      = i_id_uses_rs1 & (i_id_rs1 == i_ex_rd);
    assign w_rs2_hit      = i_id_uses_rs2 & (i_id_rs2 == i_ex_rd);
    assign o_load_use     = w_ex_load_live & i_id_valid & (w_rs1_hit | w_rs2_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline: load-use bubbles, EX redirects,
// fetch wait, system-instruction drain and ebreak halt.
module pipeline_ctrl
    import pipeline_pkg::*;
#(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             id_valid_i,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic             id_uses_rs1_i,
    input  logic             id_uses_rs2_i,
    input  logic             id_is_system_i,
    input  logic             id_is_ebreak_i,
    input  logic             ex_valid_i,
    input  logic [4:0]       ex_rd_i,
    input  logic             ex_is_load_i,
    input  logic             ex_redirect_i,
    input  logic             imem_ready_i,
    output logic             pc_en_o,
    output logic             ifid_stall_o,
    output logic             ifid_flush_o,
    output logic             idex_flush_o,
    output logic             sys_go_o,
    output logic             halted_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam int            DW         = $clog2(DRAIN_CYCLES + 1);
    localparam logic [DW-1:0] DRAIN_INIT = DW'(DRAIN_CYCLES - 1);

    ctrl_state_e      r_state;
    ctrl_state_e      w_next_state;
    logic [DW-1:0]    r_cnt;
    logic [DW-1:0]    w_next_cnt;
    logic [CNT_W-1:0] r_stall_cnt;
    ctrl_out_t        w_ctl;
    logic             w_sys_go;
    logic             w_load_use;
    logic             w_redirect;
    logic             w_sys_enter;

    hazard_detect u_hazard_detect (
        .i_id_valid    (id_valid_i),
        .i_id_rs1      (id_rs1_i),
        .i_id_rs2      (id_rs2_i),
        .i_id_uses_rs1 (id_uses_rs1_i),
        .i_id_uses_rs2 (id_uses_rs2_i),
        .i_ex_valid    (ex_valid_i),
        .i_ex_rd       (ex_rd_i),
        .i_ex_is_load  (ex_is_load_i),
        .o_load_use    (w_load_use)
    );

    assign w_redirect = ex_valid_i & ex_redirect_i;
    // A system instr that is also load-use takes the bubble first and enters DRAIN next cycle.
    assign w_sys_enter = id_valid_i & id_is_system_i & ~w_load_use;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= CTRL_RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        case (r_state)
            CTRL_RUN: begin
                if (!w_redirect && w_sys_enter) begin
                    w_next_state = CTRL_DRAIN;
                    w_next_cnt   = DRAIN_INIT;
                end
            end
            CTRL_DRAIN: begin
                if (w_redirect) begin
                    w_next_state = CTRL_RUN;
                    w_next_cnt   = '0;
                end else if (r_cnt != '0) begin
                    w_next_cnt = r_cnt - DW'(1);
                end else begin
                    w_next_state = id_is_ebreak_i ? CTRL_HALT : CTRL_RUN;
                end
            end
            CTRL_HALT: begin
                w_next_state = CTRL_HALT;
            end
            default: begin
                w_next_state = CTRL_RUN;
                w_next_cnt   = '0;
            end
        endcase
    end

    always_comb begin
        w_ctl    = CTL_NORMAL;
        w_sys_go = 1'b0;
        if (rst_i) begin
            w_ctl = CTL_RESET;
        end else if (r_state == CTRL_HALT) begin
            w_ctl = CTL_HOLD;
        end else if (w_redirect) begin
            w_ctl = CTL_REDIRECT;
        end else if (r_state == CTRL_DRAIN) begin
            if (r_cnt != '0) begin
                w_ctl = CTL_HOLD;
            end else begin
                w_sys_go = 1'b1;
            end
        end else if (w_sys_enter || w_load_use) begin
            w_ctl = CTL_HOLD;
        end else if (!imem_ready_i) begin
            w_ctl = CTL_FETCH_WAIT;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_stall_cnt <= '0;
        end else if (!w_ctl.pc_en && r_state != CTRL_HALT) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign pc_en_o      = w_ctl.pc_en;
    assign ifid_stall_o = w_ctl.ifid_stall;
    assign ifid_flush_o = w_ctl.ifid_flush;
    assign idex_flush_o = w_ctl.idex_flush;
    assign sys_go_o     = w_sys_go;
    assign halted_o     = (r_state == CTRL_HALT);
    assign state_o      = r_state;
    assign stall_cnt_o  = r_stall_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: load-use, x0 loads, redirects, drain, fetch wait,
// reset mid-drain and ebreak halt, with hand-computed control vectors.
module tb_pipeline_ctrl;

    localparam logic [3:0] E_NORMAL = 4'b1000;
    localparam logic [3:0] E_HOLD   = 4'b0101;
    localparam logic [3:0] E_REDIR  = 4'b1011;
    localparam logic [3:0] E_FETCHW = 4'b0010;
    localparam logic [3:0] E_RESET  = 4'b0011;
    localparam logic [1:0] S_RUN    = 2'd0;
    localparam logic [1:0] S_DRAIN  = 2'd1;
    localparam logic [1:0] S_HALT   = 2'd2;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_uses_rs1, id_uses_rs2, id_is_system, id_is_ebreak;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        ex_valid, ex_is_load, ex_redirect, imem_ready;
    logic        pc_en, ifid_stall, ifid_flush, idex_flush, sys_go, halted;
    logic [1:0]  state;
    logic [31:0] stall_cnt;
    logic [3:0]  ctl_obs;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_stall = 0;

    pipeline_ctrl #(.DRAIN_CYCLES(3), .CNT_W(32)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .id_valid_i     (id_valid),
        .id_rs1_i       (id_rs1),
        .id_rs2_i       (id_rs2),
        .id_uses_rs1_i  (id_uses_rs1),
        .id_uses_rs2_i  (id_uses_rs2),
        .id_is_system_i (id_is_system),
        .id_is_ebreak_i (id_is_ebreak),
        .ex_valid_i     (ex_valid),
        .ex_rd_i        (ex_rd),
        .ex_is_load_i   (ex_is_load),
        .ex_redirect_i  (ex_redirect),
        .imem_ready_i   (imem_ready),
        .pc_en_o        (pc_en),
        .ifid_stall_o   (ifid_stall),
        .ifid_flush_o   (ifid_flush),
        .idex_flush_o   (idex_flush),
        .sys_go_o       (sys_go),
        .halted_o       (halted),
        .state_o        (state),
        .stall_cnt_o    (stall_cnt)
    );

    always #5 clk = ~clk;

    assign ctl_obs = {pc_en, ifid_stall, ifid_flush, idex_flush};

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic set_idle();
        id_valid     = 1'b0;
        id_rs1       = 5'd0;
        id_rs2       = 5'd0;
        id_uses_rs1  = 1'b0;
        id_uses_rs2  = 1'b0;
        id_is_system = 1'b0;
        id_is_ebreak = 1'b0;
        ex_valid     = 1'b0;
        ex_rd        = 5'd0;
        ex_is_load   = 1'b0;
        ex_redirect  = 1'b0;
        imem_ready   = 1'b1;
    endtask

    // Inputs are set just after a rising edge; outputs are checked 1ns later, then one clock elapses.
    task automatic cycle(input string tag, input logic [3:0] exp_ctl, input logic exp_go,
                         input logic [1:0] exp_state);
        #1;
        check({tag, ".ctl"},   32'(ctl_obs), 32'(exp_ctl));
        check({tag, ".go"},    32'(sys_go),  32'(exp_go));
        check({tag, ".state"}, 32'(state),   32'(exp_state));
        check({tag, ".halt"},  32'(halted),  32'(exp_state == S_HALT));
        check({tag, ".scnt"},  stall_cnt,    exp_stall);
        @(posedge clk);
        if (!exp_ctl[3] && exp_state != S_HALT) exp_stall++;
        #1;
    endtask

    initial begin
        set_idle();
        rst = 1'b1;
        #3;
        check("rst.ctl",   32'(ctl_obs),   32'(E_RESET));
        check("rst.state", 32'(state),     32'(S_RUN));
        check("rst.scnt",  stall_cnt,      32'd0);
        check("rst.go",    32'(sys_go),    32'd0);
        check("rst.halt",  32'(halted),    32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle("idle", E_NORMAL, 1'b0, S_RUN);

        // ld x5 in EX, ID reads x5 via rs1: exactly one bubble
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd5;
        id_valid = 1'b1; id_uses_rs1 = 1'b1; id_rs1 = 5'd5;
        cycle("lu_rs1", E_HOLD, 1'b0, S_RUN);
        ex_valid = 1'b0;
        cycle("lu_rs1_after", E_NORMAL, 1'b0, S_RUN);

        // rs2 match counts only when rs2 is actually read
        ex_valid = 1'b1; ex_rd = 5'd7; id_uses_rs1 = 1'b0; id_rs2 = 5'd7; id_uses_rs2 = 1'b0;
        cycle("lu_rs2_unused", E_NORMAL, 1'b0, S_RUN);
        id_uses_rs2 = 1'b1;
        cycle("lu_rs2", E_HOLD, 1'b0, S_RUN);

        // ld x0 never hazards
        ex_rd = 5'd0; id_rs1 = 5'd0; id_uses_rs1 = 1'b1; id_rs2 = 5'd0;
        cycle("lu_x0", E_NORMAL, 1'b0, S_RUN);

        // redirect wins over a same-cycle load-use
        ex_rd = 5'd9; id_rs1 = 5'd9; ex_redirect = 1'b1;
        cycle("redir_lu", E_REDIR, 1'b0, S_RUN);
        set_idle();
        cycle("redir_after", E_NORMAL, 1'b0, S_RUN);

        // ecall: three held cycles, release on the fourth, back to RUN
        id_valid = 1'b1; id_is_system = 1'b1;
        cycle("ecall_h1", E_HOLD, 1'b0, S_RUN);
        cycle("ecall_h2", E_HOLD, 1'b0, S_DRAIN);
        cycle("ecall_h3", E_HOLD, 1'b0, S_DRAIN);
        cycle("ecall_go", E_NORMAL, 1'b1, S_DRAIN);
        set_idle();
        cycle("ecall_run", E_NORMAL, 1'b0, S_RUN);

        // ecall aborted by a redirect on its second cycle
        id_valid = 1'b1; id_is_system = 1'b1;
        cycle("abort_h1", E_HOLD, 1'b0, S_RUN);
        ex_valid = 1'b1; ex_redirect = 1'b1;
        cycle("abort_redir", E_REDIR, 1'b0, S_DRAIN);
        set_idle();
        cycle("abort_run", E_NORMAL, 1'b0, S_RUN);
        cycle("abort_quiet", E_NORMAL, 1'b0, S_RUN);

        // system instr that is also load-use: bubble first, then drain
        id_valid = 1'b1; id_is_system = 1'b1; id_uses_rs1 = 1'b1; id_rs1 = 5'd3;
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd3;
        cycle("syslu_bubble", E_HOLD, 1'b0, S_RUN);
        ex_valid = 1'b0;
        cycle("syslu_h1", E_HOLD, 1'b0, S_RUN);
        cycle("syslu_h2", E_HOLD, 1'b0, S_DRAIN);
        cycle("syslu_h3", E_HOLD, 1'b0, S_DRAIN);
        cycle("syslu_go", E_NORMAL, 1'b1, S_DRAIN);
        set_idle();

        // two cycles of fetch wait
        imem_ready = 1'b0;
        cycle("fw_1", E_FETCHW, 1'b0, S_RUN);
        cycle("fw_2", E_FETCHW, 1'b0, S_RUN);
        imem_ready = 1'b1;
        cycle("fw_done", E_NORMAL, 1'b0, S_RUN);
        check("fw_total", stall_cnt, 32'd12);

        // reset asserted mid-drain
        id_valid = 1'b1; id_is_system = 1'b1;
        cycle("rd_h1", E_HOLD, 1'b0, S_RUN);
        cycle("rd_h2", E_HOLD, 1'b0, S_DRAIN);
        rst = 1'b1;
        exp_stall = 0;
        #1;
        check("rd_rst.state", 32'(state),   32'(S_RUN));
        check("rd_rst.scnt",  stall_cnt,    32'd0);
        check("rd_rst.ctl",   32'(ctl_obs), 32'(E_RESET));
        check("rd_rst.go",    32'(sys_go),  32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        set_idle();
        cycle("rd_run", E_NORMAL, 1'b0, S_RUN);

        // ebreak: drain, release, then halt with the stall counter frozen
        id_valid = 1'b1; id_is_system = 1'b1; id_is_ebreak = 1'b1;
        cycle("eb_h1", E_HOLD, 1'b0, S_RUN);
        cycle("eb_h2", E_HOLD, 1'b0, S_DRAIN);
        cycle("eb_h3", E_HOLD, 1'b0, S_DRAIN);
        cycle("eb_go", E_NORMAL, 1'b1, S_DRAIN);
        set_idle();
        cycle("halt_1", E_HOLD, 1'b0, S_HALT);
        imem_ready = 1'b0; ex_valid = 1'b1; ex_redirect = 1'b1;
        cycle("halt_redir", E_HOLD, 1'b0, S_HALT);
        cycle("halt_3", E_HOLD, 1'b0, S_HALT);
        check("halt_frozen", stall_cnt, 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
